// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI burst sequencer.
//   - state_e        : sequencer FSM states
//   - DefaultDepth   : default TX/RX FIFO depth (bytes)
//   - DefaultTimeout : default per-byte driver timeout (clk cycles)
package spi_pkg;

    localparam int unsigned DefaultDepth   = 8;
    localparam int unsigned DefaultTimeout = 255;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitEn,
        StWaitDone,
        StCapture,
        StFinish
    } state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous 8-bit FIFO, DEPTH entries (power of two).
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset (pointers and count cleared)
//   push_i     : write wr_data_i this cycle
//   wr_data_i  : byte to write
//   pop_i      : discard the head this cycle
//   rd_data_o  : head byte (first-word fall-through)
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : occupancy, $clog2(DEPTH)+1 bits
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A push and a pop in the same cycle are both honoured even at the
    // full/empty boundary, so the occupancy holds steady.
    assign do_push = push_i & (~full_o  | pop_i);
    assign do_pop  = pop_i  & (~empty_o | push_i);

    // When empty the incoming byte is the head, so a same-cycle push/pop
    // passes it straight through and order is kept.
    assign rd_data_o = empty_o ? wr_data_i : mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: feeds bursts of bytes from a TX FIFO to a byte-wide
// SPI driver and collects the returned bytes into an RX FIFO.
// Ports:
//   clk, rst (sync, active-low)
//   wr_data/wr_valid/wr_ready   : TX FIFO push handshake
//   burst_len/burst_go          : burst request (len sampled on go)
//   busy/done/err               : burst status (done/err are 1-cycle pulses)
//   rd_data/rd_valid/rd_ready   : RX FIFO pop handshake
//   drv_data/drv_start          : byte and start strobe to the SPI driver
//   drv_en/drv_rdata            : driver activity flag and returned byte
module spi_burst_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [$clog2(DEPTH):0] burst_len,
    input  logic                   burst_go,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [7:0]             drv_data,
    output logic                   drv_start,
    input  logic                   drv_en,
    input  logic [7:0]             drv_rdata
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e        state_q;
    logic [CW-1:0] remaining_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    drv_data_q;
    logic          drv_start_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;

    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_count;

    logic          go_accept;

    assign tx_push  = wr_valid & wr_ready;
    assign tx_pop   = (state_q == StLoad);
    assign rx_push  = (state_q == StCapture);
    assign rx_pop   = rd_valid & rd_ready;

    assign wr_ready = ~tx_full;
    assign rd_valid = ~rx_empty;

    // Only start a burst that can run to completion without the TX side
    // running dry or the RX side overflowing.
    assign go_accept = burst_go && (state_q == StIdle) && (burst_len != '0)
                       && (burst_len <= tx_count)
                       && (burst_len <= (CW'(DEPTH) - rx_count));

    spi_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (tx_push),
        .wr_data_i (wr_data),
        .pop_i     (tx_pop),
        .rd_data_o (tx_head),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .count_o   (tx_count)
    );

    spi_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (rx_push),
        .wr_data_i (drv_rdata),
        .pop_i     (rx_pop),
        .rd_data_o (rd_data),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .count_o   (rx_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            timer_q     <= '0;
            drv_data_q  <= '0;
            drv_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            drv_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go_accept) begin
                        remaining_q <= burst_len;
                        busy_q      <= 1'b1;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    drv_data_q  <= tx_head;
                    // Registered so the strobe is high exactly while in StStart.
                    drv_start_q <= 1'b1;
                    state_q     <= StStart;
                end
                StStart: begin
                    timer_q <= '0;
                    state_q <= StWaitEn;
                end
                StWaitEn, StWaitDone: begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (state_q == StWaitEn && drv_en) begin
                            state_q <= StWaitDone;
                        end else if (state_q == StWaitDone && !drv_en) begin
                            state_q <= StCapture;
                        end
                    end
                end
                StCapture: begin
                    remaining_q <= remaining_q - 1'b1;
                    state_q     <= (remaining_q > CW'(1)) ? StLoad : StFinish;
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign drv_data  = drv_data_q;
    assign drv_start = drv_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
